// File: rtl/nios2_qsys_pio_led_pwm.sv
// LED PIO with per-channel blink and a shared 8-bit PWM dimmer, Avalon-MM slave.
module nios2_qsys_pio_led_pwm #(
   parameter int unsigned               WIDTH          = 8,
   parameter logic [WIDTH-1:0]          RESET_VALUE    = '1,
   parameter int unsigned               PRESCALE_WIDTH = 24,
   parameter logic [PRESCALE_WIDTH-1:0] PERIOD_DEFAULT = PRESCALE_WIDTH'(4_999_999)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam int unsigned DUTY_W    = 8;
   localparam logic [2:0]  A_DATA    = 3'd0;
   localparam logic [2:0]  A_MODE    = 3'd1;
   localparam logic [2:0]  A_PERIOD  = 3'd2;
   localparam logic [2:0]  A_CTRL    = 3'd3;
   localparam logic [2:0]  A_OUTSET  = 3'd4;
   localparam logic [2:0]  A_OUTCLR  = 3'd5;
   localparam logic [2:0]  A_DUTY    = 3'd6;
   localparam logic [DUTY_W-1:0] PWM_LAST  = 8'd254;
   localparam logic [DUTY_W-1:0] DUTY_FULL = 8'd255;

   logic [WIDTH-1:0]          data;
   logic [WIDTH-1:0]          mode;
   logic [PRESCALE_WIDTH-1:0] period;
   logic [DUTY_W-1:0]         duty;
   logic [PRESCALE_WIDTH-1:0] blink_cnt;
   logic                      phase;
   logic [DUTY_W-1:0]         pwm_cnt;
   logic                      pwm_on;
   logic                      wr_en;
   logic                      unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   // writedata bits above every register width are intentionally dropped
   assign unused_wdata = ^writedata;

   // Software-visible registers: DATA (with set/clear aliases), MODE, PERIOD, DUTY
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data   <= RESET_VALUE;
         mode   <= '0;
         period <= PERIOD_DEFAULT;
         duty   <= DUTY_FULL;
      end else if (wr_en) begin
         case (address)
            A_DATA:   data   <= writedata[WIDTH-1:0];
            A_MODE:   mode   <= writedata[WIDTH-1:0];
            A_PERIOD: period <= writedata[PRESCALE_WIDTH-1:0];
            A_OUTSET: data   <= data | writedata[WIDTH-1:0];
            A_OUTCLR: data   <= data & ~writedata[WIDTH-1:0];
            A_DUTY:   duty   <= writedata[DUTY_W-1:0];
            default:  ;
         endcase
      end
   end

   // Blink prescaler; CTRL restart wins over a wrap toggle on the same edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (wr_en && address == A_CTRL) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (wr_en && address == A_PERIOD) begin
         blink_cnt <= '0;
      end else if (blink_cnt == period) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + PRESCALE_WIDTH'(1);
      end
   end

   // Free-running PWM counter, 255-cycle period
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt <= '0;
      end else if (pwm_cnt == PWM_LAST) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + DUTY_W'(1);
      end
   end

   // PWM gate; full duty keeps the LEDs on through the whole period
   always_comb begin
      pwm_on = 1'b0;
      if (duty == DUTY_FULL || pwm_cnt < duty) begin
         pwm_on = 1'b1;
      end
   end

   // Registered LED drive: blinking channels share one phase
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_port <= '0;
      end else begin
         out_port <= data & (~mode | {WIDTH{phase}}) & {WIDTH{pwm_on}};
      end
   end

   // Zero-wait-state read mux
   always_comb begin
      readdata = '0;
      case (address)
         A_DATA:   readdata = 32'(data);
         A_MODE:   readdata = 32'(mode);
         A_PERIOD: readdata = 32'(period);
         A_CTRL:   readdata = {31'b0, phase};
         A_DUTY:   readdata = 32'(duty);
         default:  readdata = '0;
      endcase
   end

endmodule

// File: doc/nios2_qsys_pio_led_pwm.md
NIOS2_QSYS_PIO_LED_PWM -- requirements
Module: nios2_qsys_pio_led_pwm

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of LED channels, legal 1..32.
REQ-002 SHALL have parameter RESET_VALUE, default all-ones (WIDTH bits): DATA register value after reset.
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 24: width of blink counter and PERIOD register, legal 1..32.
REQ-004 SHALL have parameter PERIOD_DEFAULT, default 24'd4_999_999: PERIOD register value after reset.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port address, input, 3: Avalon-MM word address.
REQ-008 SHALL have port chipselect, input, 1: slave select.
REQ-009 SHALL have port write_n, input, 1: active-low write strobe.
REQ-010 SHALL have port writedata, input, 32: write data.
REQ-011 SHALL have port readdata, output, 32: read data, zero wait states, combinational from address.
REQ-012 SHALL have port out_port, output, WIDTH: LED drive.

Function
REQ-013 A write SHALL occur on a clk edge with chipselect=1 and write_n=0; no write occurs otherwise.
REQ-014 Register map SHALL be: 0 DATA r/w; 1 MODE r/w; 2 PERIOD r/w; 3 CTRL; 4 OUTSET wo; 5 OUTCLR wo; 6 DUTY r/w; 7 reserved.
REQ-015 Writes SHALL use writedata LSBs only; bits above the register width are ignored.
REQ-016 readdata SHALL return the addressed register zero-extended to 32 bits; addresses 4, 5, 7 read 0; address 3 reads {31'b0, phase}.
REQ-017 Write to OUTSET SHALL set DATA <= DATA | writedata[WIDTH-1:0]; DATA unchanged elsewhere.
REQ-018 Write to OUTCLR SHALL set DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-019 Blink counter SHALL increment each clk; when counter == PERIOD it SHALL reload 0 and toggle phase in the same edge.
REQ-020 Blink half-period SHALL be PERIOD+1 clk cycles; PERIOD=0 toggles phase every cycle.
REQ-021 Write to PERIOD SHALL load PERIOD, clear the blink counter to 0, leave phase unchanged, with no toggle on that edge.
REQ-022 Write to CTRL (any data) SHALL clear the blink counter to 0 and force phase to 1; it overrides a same-edge wrap toggle.
REQ-023 PWM counter SHALL be 8 bits, increment each clk, wrap 254 -> 0 (period 255 cycles).
REQ-024 pwm_on SHALL be 1 when pwm_cnt < DUTY, or when DUTY == 255; DUTY == 0 gives pwm_on = 0 permanently.
REQ-025 out_port[i] SHALL be registered: out_port[i] <= DATA[i] & (~MODE[i] | phase) & pwm_on, one clk latency from state.
REQ-026 A register write SHALL be visible on readdata the cycle after the write edge and on out_port two edges after.
REQ-027 MODE[i]=1 SHALL blink channel i only; MODE[i]=0 channels follow DATA (PWM-gated) without blinking.
REQ-028 All blinking channels SHALL share the single phase and remain mutually in phase.

Reset
REQ-029 On reset_n=0, asynchronously: DATA=RESET_VALUE, MODE=0, PERIOD=PERIOD_DEFAULT, DUTY=255, blink counter=0, phase=1, pwm_cnt=0, out_port=0.
REQ-030 With defaults, out_port SHALL equal RESET_VALUE on the first clk edge after reset_n deasserts.
REQ-031 Reset asserted mid-blink or mid-PWM SHALL abort immediately; no partial state survives.

Verification
REQ-032 Reset release, no writes -> out_port = 8'hFF after first edge; readdata @0 = 32'h000000FF; @2 = PERIOD_DEFAULT.
REQ-033 Write DATA=8'h0F, OUTSET=8'h30, OUTCLR=8'h03 -> DATA reads 8'h3C; out_port = 8'h3C.
REQ-034 PERIOD=3, MODE=8'h01, DATA=8'h01, write CTRL -> out_port[0] 1 for 4 cycles, 0 for 4 cycles, repeating; other bits 0.
REQ-035 DUTY=64, DATA=8'hFF, MODE=0 -> each out_port bit high exactly 64 of every 255 cycles; DUTY=0 -> always 0; DUTY=255 -> always 1.
REQ-036 chipselect=0 with write_n=0 to DATA -> no change; writedata=32'hFFFF_FF00 to DATA -> DATA=8'h00, readdata upper 24 bits 0.
REQ-037 Assert reset_n low mid-blink with DATA=8'h00 -> out_port=0 immediately, registers at reset values; after release out_port=8'hFF.
